// File: rtl/capture_buffer_pkg.sv
// capture_buffer_pkg: state encoding and count sizing shared by the capture buffer
// and the system control stage.
package capture_buffer_pkg;

   localparam int STATE_W = 3;

   typedef logic [STATE_W-1:0] state_t;

   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd1;
   localparam logic [STATE_W-1:0] ST_READY   = 3'd2;
   localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE    = 3'd4;

   // Counts must hold 0..depth inclusive, hence the extra bit.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/capture_buffer_ram.sv
// capture_ram: simple dual-port sample RAM, one write port and one registered
// read port with a read latency of one cycle.
module capture_ram
   import capture_buffer_pkg::*;
#(
   parameter int DEPTH      = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/capture_buffer.sv
// capture_buffer: captures gated measurement words into RAM, then streams them
// in order over valid/ready with a last marker; supports re-drain and re-arm.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | after reset, nothing captured, waiting for arm
//   CAPTURE | accepting wr_vld words into RAM
//   READY   | capture finished, waiting for drain_start
//   DRAIN   | streaming stored words to the reader
//   DONE    | drain completed, data still held for a re-drain
module capture_buffer
   import capture_buffer_pkg::*;
#(
   parameter int FIFO_SIZE  = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = cnt_width(FIFO_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_vld,
   input  logic                  capture_done,
   input  logic                  drain_start,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_vld,
   input  logic                  m_rdy,
   output logic                  m_last,
   output logic [CNT_WIDTH-1:0]  buf_count,
   output logic                  ready_to_drain,
   output logic                  drain_done,
   output logic                  event_wr_when_not_capturing,
   output logic                  event_overflow
);

   localparam int ADDR_W = $clog2(FIFO_SIZE);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_SIZE);

   state_t                state;
   state_t                state_nxt;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [ADDR_W-1:0]     wr_ptr;
   logic [CNT_WIDTH-1:0]  rd_ptr;
   logic [CNT_WIDTH-1:0]  rd_ptr_cur;
   logic                  wr_en;
   logic                  rd_en;
   logic                  drain_go;
   logic                  issue_last;
   logic                  credit_ok;
   logic                  pop;
   logic                  rd_pend;
   logic                  rd_pend_last;
   logic                  drain_done_nxt;
   logic [2:0]            occ;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [1:0]            sk_cnt;
   logic [DATA_WIDTH-1:0] sk_data0;
   logic [DATA_WIDTH-1:0] sk_data1;
   logic                  sk_last0;
   logic                  sk_last1;

   assign buf_count      = cnt;
   assign ready_to_drain = (state == ST_READY) || (state == ST_DONE);
   assign m_vld          = (sk_cnt != 2'd0);
   assign m_data         = sk_data0;
   assign m_last         = m_vld & sk_last0;

   assign pop      = m_vld & m_rdy;
   assign drain_go = drain_start & ~arm & ready_to_drain;
   assign wr_en    = wr_vld & ~arm & (state == ST_CAPTURE) & (cnt != FULL_CNT);

   // Issue a read only if its data is guaranteed a skid slot when it returns.
   assign occ       = {1'b0, sk_cnt} + {2'b00, rd_pend} - {2'b00, pop};
   assign credit_ok = (occ <= 3'd1);

   // The first read goes out on the drain_start cycle so m_vld rises two cycles later.
   assign rd_ptr_cur = drain_go ? '0 : rd_ptr;
   assign rd_en      = ~arm & (drain_go || (state == ST_DRAIN)) &
                       (rd_ptr_cur < cnt) & credit_ok;
   assign issue_last = ((rd_ptr_cur + CNT_WIDTH'(1)) == cnt);

   assign drain_done_nxt = ~arm & ((pop & m_last) | (drain_go & (cnt == '0)));

   always_comb begin
      state_nxt = state;
      if (arm) begin
         state_nxt = ST_CAPTURE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_CAPTURE: begin
               if ((cnt == FULL_CNT) || capture_done) begin
                  state_nxt = ST_READY;
               end
            end
            ST_READY, ST_DONE: begin
               if (drain_start) begin
                  state_nxt = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if ((cnt == '0) || (pop && m_last)) begin
                  state_nxt = ST_DONE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                       <= ST_IDLE;
         cnt                         <= '0;
         wr_ptr                      <= '0;
         rd_ptr                      <= '0;
         rd_pend                     <= 1'b0;
         rd_pend_last                <= 1'b0;
         drain_done                  <= 1'b0;
         event_wr_when_not_capturing <= 1'b0;
         event_overflow              <= 1'b0;
      end else begin
         state                       <= state_nxt;
         drain_done                  <= drain_done_nxt;
         event_wr_when_not_capturing <= wr_vld & (state != ST_CAPTURE);
         event_overflow              <= wr_vld & (state == ST_CAPTURE) & (cnt == FULL_CNT);
         if (arm) begin
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
         end else begin
            if (wr_en) begin
               cnt    <= cnt + CNT_WIDTH'(1);
               wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            rd_pend      <= rd_en;
            rd_pend_last <= rd_en & issue_last;
            if (rd_en) begin
               rd_ptr <= rd_ptr_cur + CNT_WIDTH'(1);
            end else if (drain_go) begin
               rd_ptr <= '0;
            end
         end
      end
   end

   // Two-entry output skid: slot 0 drives the stream, slot 1 absorbs the read in flight.
   always_ff @(posedge clk) begin
      if (rst || arm) begin
         sk_cnt   <= 2'd0;
         sk_data0 <= '0;
         sk_data1 <= '0;
         sk_last0 <= 1'b0;
         sk_last1 <= 1'b0;
      end else begin
         case ({rd_pend, pop})
            2'b10: begin
               if (sk_cnt == 2'd0) begin
                  sk_data0 <= rd_data;
                  sk_last0 <= rd_pend_last;
               end else begin
                  sk_data1 <= rd_data;
                  sk_last1 <= rd_pend_last;
               end
               sk_cnt <= sk_cnt + 2'd1;
            end
            2'b01: begin
               sk_data0 <= sk_data1;
               sk_last0 <= sk_last1;
               sk_cnt   <= sk_cnt - 2'd1;
            end
            2'b11: begin
               if (sk_cnt == 2'd1) begin
                  sk_data0 <= rd_data;
                  sk_last0 <= rd_pend_last;
               end else begin
                  sk_data0 <= sk_data1;
                  sk_last0 <= sk_last1;
                  sk_data1 <= rd_data;
                  sk_last1 <= rd_pend_last;
               end
            end
            default: begin
            end
         endcase
      end
   end

   capture_ram #(
      .DEPTH      (FIFO_SIZE),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_cur[ADDR_W-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer: directed scenarios for capture_buffer with FIFO_SIZE=8.
`timescale 1ns/1ps
module tb_capture_buffer;

   logic        clk;
   logic        rst;
   logic        arm;
   logic [31:0] wr_data;
   logic        wr_vld;
   logic        capture_done;
   logic        drain_start;
   logic [31:0] m_data;
   logic        m_vld;
   logic        m_rdy;
   logic        m_last;
   logic [3:0]  buf_count;
   logic        ready_to_drain;
   logic        drain_done;
   logic        event_wr_when_not_capturing;
   logic        event_overflow;

   int pass_cnt  = 0;
   int total_cnt = 0;

   capture_buffer #(
      .FIFO_SIZE  (8),
      .DATA_WIDTH (32)
   ) dut (
      .clk                         (clk),
      .rst                         (rst),
      .arm                         (arm),
      .wr_data                     (wr_data),
      .wr_vld                      (wr_vld),
      .capture_done                (capture_done),
      .drain_start                 (drain_start),
      .m_data                      (m_data),
      .m_vld                       (m_vld),
      .m_rdy                       (m_rdy),
      .m_last                      (m_last),
      .buf_count                   (buf_count),
      .ready_to_drain              (ready_to_drain),
      .drain_done                  (drain_done),
      .event_wr_when_not_capturing (event_wr_when_not_capturing),
      .event_overflow              (event_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic write_words(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         wr_vld  = 1'b1;
         wr_data = base + 32'(i);
         tick();
      end
      wr_vld  = 1'b0;
      wr_data = '0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({m_vld, m_last, ready_to_drain, drain_done, event_wr_when_not_capturing,
           event_overflow} !== 6'b0) begin
         $display("FAIL reset_flags: got %b required 000000",
                  {m_vld, m_last, ready_to_drain, drain_done,
                   event_wr_when_not_capturing, event_overflow});
      end else pass_cnt++;
      total_cnt++;
      if ({buf_count, m_data} !== 36'h0) begin
         $display("FAIL reset_count_data: buf_count=%0d m_data=%h required 0/0",
                  buf_count, m_data);
      end else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      do_arm();
      write_words(32'h10, 8);
      total_cnt++;
      if (buf_count !== 4'd8) begin
         $display("FAIL full_count: got %0d required 8", buf_count);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (ready_to_drain !== 1'b1) begin
         $display("FAIL full_ready: got %b required 1", ready_to_drain);
      end else pass_cnt++;
      m_rdy       = 1'b1;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      total_cnt++;
      if (m_vld !== 1'b0) begin
         $display("FAIL first_vld_early: m_vld=%b one cycle after drain_start, required 0", m_vld);
      end else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_d = 32'h10 + 32'(i);
         total_cnt++;
         if ({m_vld, m_last, m_data} !== {1'b1, (i == 7), exp_d}) begin
            $display("FAIL b2b_beat%0d: vld=%b last=%b data=%h required 1/%b/%h",
                     i, m_vld, m_last, m_data, (i == 7), exp_d);
         end else pass_cnt++;
      end
      tick();
      total_cnt++;
      if ({drain_done, m_vld, ready_to_drain} !== 3'b101) begin
         $display("FAIL b2b_done: done=%b vld=%b ready=%b required 1/0/1",
                  drain_done, m_vld, ready_to_drain);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (drain_done !== 1'b0) begin
         $display("FAIL b2b_done_pulse: drain_done=%b required 0", drain_done);
      end else pass_cnt++;
   endtask

   task automatic test_stall();
      int          idx;
      int          dones;
      logic [31:0] exp_d;
      do_arm();
      write_words(32'h20, 3);
      capture_done = 1'b1;
      tick();
      capture_done = 1'b0;
      total_cnt++;
      if ({ready_to_drain, buf_count} !== {1'b1, 4'd3}) begin
         $display("FAIL stall_capture: ready=%b buf_count=%0d required 1/3",
                  ready_to_drain, buf_count);
      end else pass_cnt++;
      idx   = 0;
      dones = 0;
      m_rdy = 1'b0;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (drain_done) dones++;
         if (m_vld) begin
            exp_d = 32'h20 + 32'(idx);
            total_cnt++;
            if (idx > 2) begin
               $display("FAIL stall_extra_beat: data=%h after 3 beats", m_data);
            end else if ({m_last, m_data} !== {(idx == 2), exp_d}) begin
               $display("FAIL stall_beat%0d: last=%b data=%h required %b/%h",
                        idx, m_last, m_data, (idx == 2), exp_d);
            end else pass_cnt++;
         end
         m_rdy = ((c % 2) == 0);
         if (m_vld && m_rdy) idx++;
      end
      total_cnt++;
      if (idx !== 3 || dones !== 1) begin
         $display("FAIL stall_totals: beats=%0d drain_done pulses=%0d required 3/1", idx, dones);
      end else pass_cnt++;
      total_cnt++;
      if (buf_count !== 4'd3) begin
         $display("FAIL stall_count: got %0d required 3", buf_count);
      end else pass_cnt++;
      m_rdy = 1'b1;
   endtask

   task automatic test_overflow();
      int ovf;
      int nc;
      ovf = 0;
      nc  = 0;
      do_arm();
      for (int i = 0; i < 9; i++) begin
         wr_vld  = 1'b1;
         wr_data = 32'h30 + 32'(i);
         tick();
         if (event_overflow) ovf++;
         if (event_wr_when_not_capturing) nc++;
      end
      wr_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (event_overflow) ovf++;
         if (event_wr_when_not_capturing) nc++;
      end
      total_cnt++;
      if (ovf !== 1 || nc !== 0) begin
         $display("FAIL overflow_events: overflow=%0d not_capturing=%0d required 1/0", ovf, nc);
      end else pass_cnt++;
      total_cnt++;
      if ({ready_to_drain, buf_count} !== {1'b1, 4'd8}) begin
         $display("FAIL overflow_state: ready=%b buf_count=%0d required 1/8",
                  ready_to_drain, buf_count);
      end else pass_cnt++;
   endtask

   task automatic test_empty_drain();
      do_reset();
      wr_vld  = 1'b1;
      wr_data = 32'hdead;
      tick();
      wr_vld = 1'b0;
      total_cnt++;
      if ({event_wr_when_not_capturing, buf_count} !== {1'b1, 4'd0}) begin
         $display("FAIL idle_write: event=%b buf_count=%0d required 1/0",
                  event_wr_when_not_capturing, buf_count);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if (event_wr_when_not_capturing !== 1'b0) begin
         $display("FAIL idle_write_pulse: event=%b required 0", event_wr_when_not_capturing);
      end else pass_cnt++;
      do_arm();
      capture_done = 1'b1;
      tick();
      capture_done = 1'b0;
      total_cnt++;
      if ({ready_to_drain, buf_count} !== {1'b1, 4'd0}) begin
         $display("FAIL empty_ready: ready=%b buf_count=%0d required 1/0",
                  ready_to_drain, buf_count);
      end else pass_cnt++;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      total_cnt++;
      if ({drain_done, m_vld} !== 2'b10) begin
         $display("FAIL empty_done: done=%b vld=%b required 1/0", drain_done, m_vld);
      end else pass_cnt++;
      tick();
      total_cnt++;
      if ({drain_done, m_vld, ready_to_drain} !== 3'b001) begin
         $display("FAIL empty_after: done=%b vld=%b ready=%b required 0/0/1",
                  drain_done, m_vld, ready_to_drain);
      end else pass_cnt++;
   endtask

   task automatic test_arm_abort();
      logic [31:0] exp_d;
      int          bad;
      do_arm();
      write_words(32'h40, 8);
      tick();
      m_rdy       = 1'b1;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_d = 32'h40 + 32'(i);
         total_cnt++;
         if ({m_vld, m_data} !== {1'b1, exp_d}) begin
            $display("FAIL abort_beat%0d: vld=%b data=%h required 1/%h", i, m_vld, m_data, exp_d);
         end else pass_cnt++;
      end
      arm = 1'b1;
      tick();
      arm = 1'b0;
      total_cnt++;
      if ({m_vld, ready_to_drain, drain_done, buf_count} !== 7'b0) begin
         $display("FAIL abort_flush: vld=%b ready=%b done=%b buf_count=%0d required 0/0/0/0",
                  m_vld, ready_to_drain, drain_done, buf_count);
      end else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (m_vld || drain_done) bad++;
      end
      total_cnt++;
      if (bad !== 0) begin
         $display("FAIL abort_quiet: %0d cycles with m_vld/drain_done high, required 0", bad);
      end else pass_cnt++;
      write_words(32'h99, 1);
      total_cnt++;
      if ({event_wr_when_not_capturing, buf_count} !== {1'b0, 4'd1}) begin
         $display("FAIL abort_capture: event=%b buf_count=%0d required 0/1",
                  event_wr_when_not_capturing, buf_count);
      end else pass_cnt++;
   endtask

   task automatic test_redrain_and_reset();
      logic [31:0] exp_d;
      do_arm();
      write_words(32'h50, 5);
      capture_done = 1'b1;
      tick();
      capture_done = 1'b0;
      m_rdy = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         drain_start = 1'b1;
         tick();
         drain_start = 1'b0;
         for (int i = 0; i < 5; i++) begin
            tick();
            exp_d = 32'h50 + 32'(i);
            total_cnt++;
            if ({m_vld, m_last, m_data} !== {1'b1, (i == 4), exp_d}) begin
               $display("FAIL redrain%0d_beat%0d: vld=%b last=%b data=%h required 1/%b/%h",
                        rep, i, m_vld, m_last, m_data, (i == 4), exp_d);
            end else pass_cnt++;
         end
         tick();
         total_cnt++;
         if ({drain_done, m_vld, ready_to_drain} !== 3'b101) begin
            $display("FAIL redrain%0d_done: done=%b vld=%b ready=%b required 1/0/1",
                     rep, drain_done, m_vld, ready_to_drain);
         end else pass_cnt++;
         tick();
      end
      do_arm();
      write_words(32'h60, 2);
      wr_vld = 1'b1;
      rst    = 1'b1;
      tick();
      rst    = 1'b0;
      wr_vld = 1'b0;
      total_cnt++;
      if ({m_vld, m_last, ready_to_drain, drain_done, event_wr_when_not_capturing,
           event_overflow, buf_count, m_data} !== 42'h0) begin
         $display("FAIL rst_mid_capture: vld=%b last=%b ready=%b done=%b evw=%b evo=%b cnt=%0d data=%h required all 0",
                  m_vld, m_last, ready_to_drain, drain_done, event_wr_when_not_capturing,
                  event_overflow, buf_count, m_data);
      end else pass_cnt++;
      wr_vld = 1'b1;
      tick();
      wr_vld = 1'b0;
      total_cnt++;
      if ({event_wr_when_not_capturing, buf_count} !== {1'b1, 4'd0}) begin
         $display("FAIL rst_idle_write: event=%b buf_count=%0d required 1/0",
                  event_wr_when_not_capturing, buf_count);
      end else pass_cnt++;
      drain_start = 1'b1;
      tick();
      drain_start = 1'b0;
      tick();
      tick();
      total_cnt++;
      if ({m_vld, ready_to_drain, drain_done} !== 3'b000) begin
         $display("FAIL idle_drain_ignored: vld=%b ready=%b done=%b required 0/0/0",
                  m_vld, ready_to_drain, drain_done);
      end else pass_cnt++;
   endtask

   initial begin
      rst          = 1'b1;
      arm          = 1'b0;
      wr_data      = '0;
      wr_vld       = 1'b0;
      capture_done = 1'b0;
      drain_start  = 1'b0;
      m_rdy        = 1'b0;
      test_reset();
      test_back_to_back();
      test_stall();
      test_overflow();
      test_empty_drain();
      test_arm_abort();
      test_redrain_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
